// File: rtl/vliw_wb_scheduler_if.sv
// vliw_wb_scheduler_if: lane results, mul/div results and register-file write ports of the writeback scheduler
interface vliw_wb_scheduler_if;
    logic        r_wb_valid;
    logic [2:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        s_wb_valid;
    logic [2:0]  s_wb_rd;
    logic [31:0] s_wb_data;
    logic        md_valid;
    logic [2:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        md_issue;
    logic [2:0]  md_issue_rd;
    logic        RregWrite;
    logic [2:0]  Rd;
    logic [31:0] RwriteData;
    logic        SregWrite;
    logic [2:0]  Sd;
    logic [31:0] SwriteData;
    logic [7:0]  pending;
    logic        issue_stall;
    logic        waw_err;

    modport master (
        output r_wb_valid, r_wb_rd, r_wb_data, s_wb_valid, s_wb_rd, s_wb_data,
        output md_valid, md_rd, md_data, md_issue, md_issue_rd,
        input  md_ready, RregWrite, Rd, RwriteData, SregWrite, Sd, SwriteData,
        input  pending, issue_stall, waw_err
    );

    modport slave (
        input  r_wb_valid, r_wb_rd, r_wb_data, s_wb_valid, s_wb_rd, s_wb_data,
        input  md_valid, md_rd, md_data, md_issue, md_issue_rd,
        output md_ready, RregWrite, Rd, RwriteData, SregWrite, Sd, SwriteData,
        output pending, issue_stall, waw_err
    );
endinterface

// File: rtl/vliw_wb_scheduler.sv
// vliw_wb_scheduler: merges lane R/S results and buffered mul/div results onto the two register-file write ports
module vliw_wb_scheduler #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_LIM = 3
) (
    input logic clk,
    input logic reset,
    vliw_wb_scheduler_if.slave wb
);
    localparam int AW = $clog2(STARVE_LIM + 1);
    localparam logic [AW-1:0] LIM = AW'(STARVE_LIM);

    logic [2:0]    qRd [2];
    logic [31:0]   qData [2];
    logic [1:0]    count;
    logic [AW-1:0] age, ageNext;
    logic          rLane, sLane, hasHead, headZero, wawHit, drainR, drainS, pop, push, slot;
    logic [7:0]    setMask, clrMask;

    assign wb.md_ready = !reset && int'(count) < FIFO_DEPTH;

    // Lane arbitration, head drain/drop decision and scoreboard masks for this cycle
    always_comb begin
        sLane    = wb.s_wb_valid && wb.s_wb_rd != 3'd0;
        rLane    = wb.r_wb_valid && wb.r_wb_rd != 3'd0 && !(wb.s_wb_valid && wb.s_wb_rd == wb.r_wb_rd);
        hasHead  = count != 2'd0;
        headZero = hasHead && qRd[0] == 3'd0;
        wawHit   = hasHead && !headZero &&
                   ((wb.r_wb_valid && wb.r_wb_rd == qRd[0]) || (wb.s_wb_valid && wb.s_wb_rd == qRd[0]));
        drainR   = hasHead && !headZero && !wawHit && !wb.r_wb_valid;
        drainS   = hasHead && !headZero && !wawHit && wb.r_wb_valid && !wb.s_wb_valid;
        pop      = headZero || wawHit || drainR || drainS;
        push     = wb.md_valid && wb.md_ready;
        slot     = count == 2'd1 && !pop;
        ageNext  = (!hasHead || pop) ? '0 : (age == LIM ? age : age + 1'b1);
        clrMask  = pop ? 8'd1 << qRd[0] : 8'd0;
        setMask  = (wb.md_issue && wb.md_issue_rd != 3'd0) ? 8'd1 << wb.md_issue_rd : 8'd0;
    end

    // FIFO storage: head shifts forward on pop, new entry lands behind whatever remains
    always_ff @(posedge clk) begin
        if (pop) begin
            qRd[0]   <= qRd[1];
            qData[0] <= qData[1];
        end
        if (push) begin
            qRd[slot]   <= wb.md_rd;
            qData[slot] <= wb.md_data;
        end
    end

    // Registered write ports, occupancy, head age, stall and scoreboard
    always_ff @(posedge clk) begin
        if (reset) begin
            count          <= 2'd0;
            age            <= '0;
            wb.RregWrite   <= 1'b0;
            wb.Rd          <= 3'd0;
            wb.RwriteData  <= 32'd0;
            wb.SregWrite   <= 1'b0;
            wb.Sd          <= 3'd0;
            wb.SwriteData  <= 32'd0;
            wb.pending     <= 8'd0;
            wb.issue_stall <= 1'b0;
            wb.waw_err     <= 1'b0;
        end else begin
            count          <= count + 2'(push) - 2'(pop);
            age            <= ageNext;
            wb.RregWrite   <= rLane || drainR;
            wb.Rd          <= drainR ? qRd[0] : rLane ? wb.r_wb_rd : 3'd0;
            wb.RwriteData  <= drainR ? qData[0] : rLane ? wb.r_wb_data : 32'd0;
            wb.SregWrite   <= sLane || drainS;
            wb.Sd          <= drainS ? qRd[0] : sLane ? wb.s_wb_rd : 3'd0;
            wb.SwriteData  <= drainS ? qData[0] : sLane ? wb.s_wb_data : 32'd0;
            wb.pending     <= (wb.pending & ~clrMask) | setMask;
            wb.issue_stall <= ageNext == LIM;
            wb.waw_err     <= wawHit;
        end
    end
endmodule

// File: tb/tb_vliw_wb_scheduler.sv
// tb_vliw_wb_scheduler: directed vectors with hand-computed expectations for the writeback scheduler
module tb_vliw_wb_scheduler;
    logic clk = 1'b0;
    logic reset;
    int testsRun = 0;
    int testsFailed = 0;

    vliw_wb_scheduler_if bus();
    vliw_wb_scheduler dut (.clk(clk), .reset(reset), .wb(bus));

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.r_wb_valid = 0; bus.r_wb_rd = 0; bus.r_wb_data = 0;
        bus.s_wb_valid = 0; bus.s_wb_rd = 0; bus.s_wb_data = 0;
        bus.md_valid = 0; bus.md_rd = 0; bus.md_data = 0;
        bus.md_issue = 0; bus.md_issue_rd = 0;
    endtask

    task automatic lanes(input logic rv, input logic [2:0] rrd, input logic [31:0] rdat,
                         input logic sv, input logic [2:0] srd, input logic [31:0] sdat);
        bus.r_wb_valid = rv; bus.r_wb_rd = rrd; bus.r_wb_data = rdat;
        bus.s_wb_valid = sv; bus.s_wb_rd = srd; bus.s_wb_data = sdat;
    endtask

    task automatic md(input logic v, input logic [2:0] rd, input logic [31:0] dat);
        bus.md_valid = v; bus.md_rd = rd; bus.md_data = dat;
    endtask

    task automatic issue(input logic v, input logic [2:0] rd);
        bus.md_issue = v; bus.md_issue_rd = rd;
    endtask

    initial begin
        reset = 1;
        idle();
        step();
        step();
        checkVal("rst_ready", bus.md_ready, 0);
        checkVal("rst_rwe", bus.RregWrite, 0);
        checkVal("rst_swe", bus.SregWrite, 0);
        checkVal("rst_pending", bus.pending, 0);
        checkVal("rst_stall", bus.issue_stall, 0);
        checkVal("rst_waw", bus.waw_err, 0);
        reset = 0;
        step();
        checkVal("post_rst_ready", bus.md_ready, 1);

        // two independent lane writes
        lanes(1, 3, 32'h11, 1, 4, 32'h22);
        step();
        idle();
        checkVal("t1_rwe", bus.RregWrite, 1);
        checkVal("t1_rd", bus.Rd, 3);
        checkVal("t1_rdata", bus.RwriteData, 32'h11);
        checkVal("t1_swe", bus.SregWrite, 1);
        checkVal("t1_sd", bus.Sd, 4);
        checkVal("t1_sdata", bus.SwriteData, 32'h22);
        step();
        checkVal("t1_rwe_gone", bus.RregWrite, 0);
        checkVal("t1_swe_gone", bus.SregWrite, 0);

        // same rd on both lanes, then write to r0
        lanes(1, 5, 32'hA, 1, 5, 32'hB);
        step();
        lanes(1, 0, 32'h5, 0, 0, 0);
        checkVal("t2_rwe", bus.RregWrite, 0);
        checkVal("t2_swe", bus.SregWrite, 1);
        checkVal("t2_sd", bus.Sd, 5);
        checkVal("t2_sdata", bus.SwriteData, 32'hB);
        step();
        idle();
        checkVal("t2_r0_rwe", bus.RregWrite, 0);
        checkVal("t2_r0_swe", bus.SregWrite, 0);

        // issue to r6, result arrives with lanes idle, drains on port R
        issue(1, 6);
        step();
        issue(0, 0);
        checkVal("t3_pending_set", bus.pending, 8'h40);
        md(1, 6, 32'h99);
        step();
        md(0, 0, 0);
        checkVal("t3_no_bypass", bus.RregWrite, 0);
        step();
        checkVal("t3_rwe", bus.RregWrite, 1);
        checkVal("t3_rd", bus.Rd, 6);
        checkVal("t3_rdata", bus.RwriteData, 32'h99);
        checkVal("t3_pending_clr", bus.pending, 0);
        step();
        checkVal("t3_rwe_gone", bus.RregWrite, 0);

        // fill FIFO while both lanes stay busy, starve the head, then release
        lanes(1, 3, 32'h33, 1, 4, 32'h44);
        md(1, 1, 32'h101);
        step();
        checkVal("t4_ready1", bus.md_ready, 1);
        md(1, 7, 32'h707);
        step();
        checkVal("t4_ready_full", bus.md_ready, 0);
        checkVal("t4_lane_rd", bus.Rd, 3);
        checkVal("t4_stall0", bus.issue_stall, 0);
        md(1, 5, 32'h505);
        step();
        checkVal("t4_stall_age2", bus.issue_stall, 0);
        checkVal("t4_ready_still", bus.md_ready, 0);
        step();
        checkVal("t4_stall", bus.issue_stall, 1);
        idle();
        step();
        checkVal("t4_d1_rwe", bus.RregWrite, 1);
        checkVal("t4_d1_rd", bus.Rd, 1);
        checkVal("t4_d1_data", bus.RwriteData, 32'h101);
        checkVal("t4_d1_swe", bus.SregWrite, 0);
        checkVal("t4_stall_clr", bus.issue_stall, 0);
        step();
        checkVal("t4_d2_rwe", bus.RregWrite, 1);
        checkVal("t4_d2_rd", bus.Rd, 7);
        checkVal("t4_d2_data", bus.RwriteData, 32'h707);
        checkVal("t4_ready_free", bus.md_ready, 1);
        step();
        checkVal("t4_third_lost", bus.RregWrite, 0);

        // WAW drop: head r2 against lane S writing r2
        issue(1, 2);
        step();
        issue(0, 0);
        checkVal("t5_pending_set", bus.pending, 8'h04);
        md(1, 2, 32'h222);
        step();
        md(0, 0, 0);
        lanes(0, 0, 0, 1, 2, 32'h55);
        step();
        idle();
        checkVal("t5_waw", bus.waw_err, 1);
        checkVal("t5_rwe", bus.RregWrite, 0);
        checkVal("t5_swe", bus.SregWrite, 1);
        checkVal("t5_sd", bus.Sd, 2);
        checkVal("t5_sdata", bus.SwriteData, 32'h55);
        checkVal("t5_pending_clr", bus.pending, 0);
        step();
        checkVal("t5_waw_pulse", bus.waw_err, 0);
        checkVal("t5_swe_gone", bus.SregWrite, 0);

        // reset with two queued entries and pending=0x0C
        issue(1, 2);
        step();
        issue(1, 3);
        step();
        issue(0, 0);
        lanes(1, 5, 32'h5, 1, 6, 32'h6);
        md(1, 2, 32'h2);
        step();
        md(1, 3, 32'h3);
        step();
        md(0, 0, 0);
        checkVal("t6_pending", bus.pending, 8'h0C);
        checkVal("t6_full", bus.md_ready, 0);
        reset = 1;
        step();
        checkVal("t6_rst_rwe", bus.RregWrite, 0);
        checkVal("t6_rst_swe", bus.SregWrite, 0);
        checkVal("t6_rst_pending", bus.pending, 0);
        checkVal("t6_rst_ready", bus.md_ready, 0);
        reset = 0;
        idle();
        step();
        checkVal("t6_ready", bus.md_ready, 1);
        checkVal("t6_flushed_rwe", bus.RregWrite, 0);
        step();
        checkVal("t6_flushed_rwe2", bus.RregWrite, 0);
        checkVal("t6_flushed_swe2", bus.SregWrite, 0);
        checkVal("t6_pending_end", bus.pending, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
